alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode-to-execute issue stage that sits directly upstream of the ALU and drives its ALUop/ina/inb inputs.
//  - Two-entry elastic (skid) buffer with valid/ready handshakes on both sides.
//  - Resolves operands at enqueue by forwarding from EX and WB, then keeps snooping both forward ports while an entry waits.
//  - Holds issue on a load-use hazard until the load data arrives.
// PARAMETERS
//  XLEN    32  datapath width
//  REG_AW  5   register index width; x0 is hard zero
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  dec_valid    in   1       decode offers an instruction
//  dec_ready    out  1       stage accepts it (registered)
//  dec_aluop    in   4       ALU opcode (add 0010, sub 0110, and 0000, or 0001, ...)
//  dec_rs1/rs2  in   REG_AW  source register indices
//  dec_rd       in   REG_AW  destination register index
//  dec_rs1_val  in   XLEN    register-file read data, rs1
//  dec_rs2_val  in   XLEN    register-file read data, rs2
//  dec_imm      in   XLEN    sign-extended immediate
//  dec_use_imm  in   1       inb = imm; rs2 is ignored
//  ex_fwd_we    in   1       EX-stage result write-enable
//  ex_fwd_rd    in   REG_AW  EX-stage destination
//  ex_fwd_data  in   XLEN    EX-stage result
//  ex_fwd_busy  in   1       EX holds a load whose data is not yet valid
//  wb_fwd_we    in   1       WB write-enable
//  wb_fwd_rd    in   REG_AW  WB destination
//  wb_fwd_data  in   XLEN    WB data
//  flush        in   1       branch mispredict: discard all entries
//  alu_valid    out  1       head entry issued to ALU
//  alu_ready    in   1       ALU/EX accepts
//  alu_op       out  4       ALU opcode
//  alu_ina      out  XLEN    ALU operand a
//  alu_inb      out  XLEN    ALU operand b
//  alu_rd       out  REG_AW  destination carried alongside
// BEHAVIOUR
//  - Reset (async): state EMPTY; dec_ready=1; alu_valid=0; alu_op/ina/inb/rd=0.
//  - FSM states:
//    - EMPTY: enqueue -> ONE.
//    - ONE: enq & !deq -> FULL; deq & !enq -> EMPTY; both -> stays ONE.
//    - FULL: deq -> ONE; no enqueue is possible.
//  - Handshakes:
//    - enq = dec_valid & dec_ready.
//    - deq = alu_valid & alu_ready.
//    - dec_ready = (state != FULL), registered.
//  - Latency: an accepted instruction presents at the ALU outputs on the next cycle when the stage was EMPTY; throughput is 1/cycle.
//  - Operand select, applied at enqueue and re-applied every cycle to each held entry:
//    - Priority: EX match (we, rd==rs, rs!=0) > WB match > stored value.
//    - inb uses dec_imm when dec_use_imm=1; that operand never snoops.
//  - Register x0: rs=0 always yields 0; forwarding writes to rd=0 are ignored.
//  - Load-use: alu_valid is forced to 0 while ex_fwd_busy=1 and ex_fwd_rd matches a live rs of the head entry. The entry is retained; the stall inserts one bubble per cycle.
//  - Simultaneous enq & deq in ONE: the new entry becomes head on the next cycle and is forwarded against the same-cycle ports.
//  - Outputs are stable while alu_valid=1 and alu_ready=0, except operand words updated by snoop.
//  - Flush (synchronous):
//    - Next state EMPTY, alu_valid=0; beats the same-cycle enqueue.
//    - dec_ready=1 on the next cycle.
//  - Reset mid-operation: all entries dropped, no partial issue.
//  - All arithmetic is pass-through; no width changes. alu_rd is passed through unchanged.
// CONFIGURATION
//  ALU_ISSUE_FWD_EN
//    - Defined: forwarding/snoop and load-use stall as above.
//    - Undefined: operands come from dec_*_val/imm only; ex_fwd_* and wb_fwd_* are ignored; no stall. Decode is responsible for hazards. FSM and handshakes are unchanged.
// STRUCTURE
//  Shared package (cpu_pkg):
//    - ALUop encoding constants (ALU_ADD=4'b0010, ALU_SUB=4'b0110, ...).
//    - XLEN, REG_AW.
//    - Issue-entry struct {op, a, b, rs1, rs2, use_imm, rd}.
//  Sub-module: alu_fwd_mux (one operand: stored value, rs, ex port, wb port -> resolved value); instantiated 2x per entry.
// TESTING
//  1. Reset mid-stream with 2 entries held -> alu_valid=0, dec_ready=1 immediately; no stale issue after release.
//  2. Back-to-back add x3=x1+x2, alu_ready=1 -> one issue per cycle, 1-cycle latency, alu_op=4'b0010.
//  3. Hold alu_ready=0 for 3 cycles -> FULL after 2 accepts, dec_ready=0, outputs stable; release -> in-order drain.
//  4. Forwarding precedence: rs1=5, ex_fwd rd=5 data=0xAAAA_0000, wb_fwd rd=5 data=0x1234 -> alu_ina=0xAAAA_0000. With rs1=0 and a matching rd=0 -> ina=0.
//  5. Load-use: ex_fwd_busy=1, rd=7, head rs2=7 -> alu_valid=0. Next cycle busy=0, ex_fwd data=0x55 -> issues with inb=0x55.
//  6. flush with enq and a held entry -> nothing issues next cycle, state EMPTY. With the FWD macro undefined, test 4 yields the register-file value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths, ALU opcodes, issue-entry layout and issue-stage state.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_imm;
    logic [REG_AW-1:0] rd;
  } issue_ent_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } iss_state_t;

  typedef enum logic [1:0] {
    HEAD_HOLD = 2'd0,
    HEAD_NEW  = 2'd1,
    HEAD_TAIL = 2'd2
  } head_sel_t;

  // A forwarding port hits only on an enabled write to the same non-zero register.
  function automatic logic rs_hit(input logic we, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Resolves one operand word: x0 -> 0, else EX hit > WB hit > stored value.
// Combinational; with ALU_ISSUE_FWD_EN undefined the stored value passes straight through.
module alu_fwd_mux
  import cpu_pkg::*;
(
  input  logic              snoop,
  input  logic [XLEN-1:0]   stored,
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   val
);

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    val = stored;
    if (snoop) begin
      if (rs == '0)                    val = '0;
      else if (rs_hit(ex_we, ex_rd, rs)) val = ex_data;
      else if (rs_hit(wb_we, wb_rd, rs)) val = wb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{snoop, rs, ex_we, ex_rd, ex_data, wb_we, wb_rd, wb_data};
  assign val = stored;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue skid buffer feeding the ALU; head shows one cycle after enqueue into EMPTY.
// dec_ready drops only when both entries are held; ALU_ISSUE_FWD_EN enables forwarding and load-use stall.
module alu_issue_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [3:0]        dec_aluop,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [XLEN-1:0]   dec_rs1_val,
  input  logic [XLEN-1:0]   dec_rs2_val,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic              dec_use_imm,
  input  logic              ex_fwd_we,
  input  logic [REG_AW-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic              ex_fwd_busy,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  input  logic              flush,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   alu_ina,
  output logic [XLEN-1:0]   alu_inb,
  output logic [REG_AW-1:0] alu_rd
);

  iss_state_t state, state_nxt;
  head_sel_t  head_sel;
  logic       tail_ld;
  logic       enq, deq, stall;

  issue_ent_t head, tail, enq_ent, head_res, tail_res;
  logic [XLEN-1:0] enq_a, enq_b, head_a, head_b, tail_a, tail_b;

  alu_fwd_mux u_enq_a (
    .snoop(1'b1), .stored(dec_rs1_val), .rs(dec_rs1),
    .ex_we(ex_fwd_we), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_we(wb_fwd_we), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .val(enq_a)
  );
  alu_fwd_mux u_enq_b (
    .snoop(!dec_use_imm), .stored(dec_use_imm ? dec_imm : dec_rs2_val), .rs(dec_rs2),
    .ex_we(ex_fwd_we), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_we(wb_fwd_we), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .val(enq_b)
  );
  alu_fwd_mux u_head_a (
    .snoop(1'b1), .stored(head.a), .rs(head.rs1),
    .ex_we(ex_fwd_we), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_we(wb_fwd_we), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .val(head_a)
  );
  alu_fwd_mux u_head_b (
    .snoop(!head.use_imm), .stored(head.b), .rs(head.rs2),
    .ex_we(ex_fwd_we), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_we(wb_fwd_we), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .val(head_b)
  );
  alu_fwd_mux u_tail_a (
    .snoop(1'b1), .stored(tail.a), .rs(tail.rs1),
    .ex_we(ex_fwd_we), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_we(wb_fwd_we), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .val(tail_a)
  );
  alu_fwd_mux u_tail_b (
    .snoop(!tail.use_imm), .stored(tail.b), .rs(tail.rs2),
    .ex_we(ex_fwd_we), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
    .wb_we(wb_fwd_we), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .val(tail_b)
  );

  always_comb begin
    enq_ent         = '0;
    enq_ent.op      = dec_aluop;
    enq_ent.a       = enq_a;
    enq_ent.b       = enq_b;
    enq_ent.rs1     = dec_rs1;
    enq_ent.rs2     = dec_rs2;
    enq_ent.use_imm = dec_use_imm;
    enq_ent.rd      = dec_rd;
    head_res        = head;
    head_res.a      = head_a;
    head_res.b      = head_b;
    tail_res        = tail;
    tail_res.a      = tail_a;
    tail_res.b      = tail_b;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Hold the head while EX still owes load data to one of its live sources.
  assign stall = ex_fwd_busy &&
                 (((head.rs1 != '0) && (ex_fwd_rd == head.rs1)) ||
                  (!head.use_imm && (head.rs2 != '0) && (ex_fwd_rd == head.rs2)));
`else
  logic unused_busy;
  assign unused_busy = ex_fwd_busy;
  assign stall       = 1'b0;
`endif

  assign alu_valid = (state != ST_EMPTY) && !stall;
  assign enq       = dec_valid && dec_ready;
  assign deq       = alu_valid && alu_ready;

  assign alu_op  = head.op;
  assign alu_ina = head_res.a;
  assign alu_inb = head_res.b;
  assign alu_rd  = head.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      dec_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      dec_ready <= (state_nxt != ST_FULL);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (enq) state_nxt = ST_ONE;
      ST_ONE: begin
        if (enq && !deq)      state_nxt = ST_FULL;
        else if (deq && !enq) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (deq) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  always_comb begin
    head_sel = HEAD_HOLD;
    tail_ld  = 1'b0;
    case (state)
      ST_EMPTY: if (enq) head_sel = HEAD_NEW;
      ST_ONE: begin
        if (enq && deq) head_sel = HEAD_NEW;
        else if (enq)   tail_ld  = 1'b1;
      end
      ST_FULL:  if (deq) head_sel = HEAD_TAIL;
      default:  head_sel = HEAD_HOLD;
    endcase
  end

  // Held entries store their snooped operands every cycle so a forward is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (head_sel)
        HEAD_NEW:  head <= enq_ent;
        HEAD_TAIL: head <= tail_res;
        default:   head <= head_res;
      endcase
      tail <= tail_ld ? enq_ent : tail_res;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed checks of alu_issue_stage against a queue-based issue model.
module tb_alu_issue_stage;
  import cpu_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_valid, dec_ready, dec_use_imm;
  logic [3:0]        dec_aluop;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]   dec_rs1_val, dec_rs2_val, dec_imm;
  logic              ex_fwd_we, ex_fwd_busy, wb_fwd_we, flush;
  logic [REG_AW-1:0] ex_fwd_rd, wb_fwd_rd;
  logic [XLEN-1:0]   ex_fwd_data, wb_fwd_data;
  logic              alu_valid, alu_ready;
  logic [3:0]        alu_op;
  logic [XLEN-1:0]   alu_ina, alu_inb;
  logic [REG_AW-1:0] alu_rd;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_aluop(dec_aluop),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .ex_fwd_busy(ex_fwd_busy),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_rd(alu_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm;
  } m_ent_t;

  m_ent_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] ops [6] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operand as the issue rules define it against the current forward ports.
  function automatic logic [31:0] res(input logic [31:0] v, input logic [4:0] rs, input logic snoop);
    if (!FWD || !snoop) return v;
    if (rs == 5'd0) return 32'd0;
    if (ex_fwd_we && ex_fwd_rd == rs) return ex_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
    return v;
  endfunction

  function automatic logic stalled();
    if (!FWD || q.size() == 0 || !ex_fwd_busy) return 1'b0;
    return (q[0].rs1 != 0 && ex_fwd_rd == q[0].rs1) ||
           (!q[0].use_imm && q[0].rs2 != 0 && ex_fwd_rd == q[0].rs2);
  endfunction

  // Compare DUT against the model for this cycle's inputs, then advance the model.
  task automatic eval();
    logic   exp_vld, exp_rdy;
    m_ent_t e;
    #1;
    if (rst) begin
      q.delete();
      chk("rst_valid", 64'(alu_valid), 64'd0);
      chk("rst_ready", 64'(dec_ready), 64'd1);
      chk("rst_op",    64'(alu_op),    64'd0);
      chk("rst_ina",   64'(alu_ina),   64'd0);
      chk("rst_inb",   64'(alu_inb),   64'd0);
      chk("rst_rd",    64'(alu_rd),    64'd0);
    end else begin
      exp_rdy = (q.size() < 2);
      exp_vld = (q.size() > 0) && !stalled();
      chk("valid", 64'(alu_valid), 64'(exp_vld));
      chk("ready", 64'(dec_ready), 64'(exp_rdy));
      if (q.size() > 0) begin
        chk("op",  64'(alu_op),  64'(q[0].op));
        chk("ina", 64'(alu_ina), 64'(res(q[0].a, q[0].rs1, 1'b1)));
        chk("inb", 64'(alu_inb), 64'(res(q[0].b, q[0].rs2, !q[0].use_imm)));
        chk("rd",  64'(alu_rd),  64'(q[0].rd));
      end
      foreach (q[i]) begin
        q[i].a = res(q[i].a, q[i].rs1, 1'b1);
        q[i].b = res(q[i].b, q[i].rs2, !q[i].use_imm);
      end
      if (flush) q.delete();
      else begin
        if (exp_vld && alu_ready) void'(q.pop_front());
        if (dec_valid && exp_rdy) begin
          e.op = dec_aluop; e.rs1 = dec_rs1; e.rs2 = dec_rs2; e.rd = dec_rd;
          e.use_imm = dec_use_imm;
          e.a = res(dec_rs1_val, dec_rs1, 1'b1);
          e.b = dec_use_imm ? dec_imm : res(dec_rs2_val, dec_rs2, 1'b1);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic idle();
    dec_valid = 0; dec_aluop = ALU_ADD; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rs1_val = 0; dec_rs2_val = 0; dec_imm = 0; dec_use_imm = 0;
    ex_fwd_we = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_busy = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0; flush = 0; alu_ready = 1;
  endtask

  task automatic add_instr(input logic [31:0] a, input logic [31:0] b);
    dec_valid = 1; dec_aluop = ALU_ADD; dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd3;
    dec_rs1_val = a; dec_rs2_val = b; dec_use_imm = 0;
  endtask

  task automatic rand_in();
    dec_valid   = ($urandom_range(0, 3) != 0);
    dec_aluop   = ops[$urandom_range(0, 5)];
    dec_rs1     = 5'($urandom_range(0, 7));
    dec_rs2     = 5'($urandom_range(0, 7));
    dec_rd      = 5'($urandom_range(0, 31));
    dec_rs1_val = $urandom;
    dec_rs2_val = $urandom;
    dec_imm     = $urandom;
    dec_use_imm = ($urandom_range(0, 3) == 0);
    ex_fwd_we   = ($urandom_range(0, 1) != 0);
    ex_fwd_rd   = 5'($urandom_range(0, 7));
    ex_fwd_data = $urandom;
    ex_fwd_busy = ($urandom_range(0, 3) == 0);
    wb_fwd_we   = ($urandom_range(0, 1) != 0);
    wb_fwd_rd   = 5'($urandom_range(0, 7));
    wb_fwd_data = $urandom;
    flush       = ($urandom_range(0, 31) == 0);
    alu_ready   = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    idle();
    rst = 1;
    adv(); eval(); adv();
    rst = 0;
    eval(); adv();

    // Back-to-back adds, one issue per cycle.
    for (int i = 0; i < 3; i++) begin
      add_instr(32'h10 + 32'(i), 32'h20);
      eval();
      if (i > 0) chk("t2_op", 64'(alu_op), 64'h2);
      if (i > 0) chk("t2_valid", 64'(alu_valid), 64'd1);
      adv();
    end
    dec_valid = 0;
    eval(); chk("t2_last", 64'(alu_valid), 64'd1); adv();
    eval(); chk("t2_empty", 64'(alu_valid), 64'd0); adv();

    // Backpressure: fill, hold, drain in order.
    alu_ready = 0;
    add_instr(32'h100, 32'h1); eval(); adv();
    add_instr(32'h200, 32'h2); eval(); adv();
    add_instr(32'h300, 32'h3);
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("t3_ready", 64'(dec_ready), 64'd0);
      chk("t3_hold", 64'(alu_ina), 64'h100);
      adv();
    end
    dec_valid = 0; alu_ready = 1;
    eval(); chk("t3_first", 64'(alu_ina), 64'h100); adv();
    eval(); chk("t3_second", 64'(alu_ina), 64'h200); adv();
    eval(); adv();

    // Forwarding precedence, then x0.
    alu_ready = 0; dec_valid = 1; dec_rs1 = 5'd5; dec_rs1_val = 32'h1111;
    dec_use_imm = 1; dec_imm = 32'h9;
    ex_fwd_we = 1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'hAAAA_0000;
    wb_fwd_we = 1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h1234;
    eval(); adv();
    dec_valid = 0; alu_ready = 1;
    eval(); chk("t4_prec", 64'(alu_ina), FWD ? 64'hAAAA_0000 : 64'h1111); adv();
    alu_ready = 0; dec_valid = 1; dec_rs1 = 5'd0; dec_rs1_val = 32'h2222;
    ex_fwd_rd = 5'd0; ex_fwd_data = 32'hDEAD; wb_fwd_rd = 5'd0;
    eval(); adv();
    dec_valid = 0; alu_ready = 1;
    eval(); chk("t4_x0", 64'(alu_ina), FWD ? 64'd0 : 64'h2222); adv();
    idle(); eval(); adv();

    // Load-use stall.
    dec_valid = 1; dec_rs1 = 5'd0; dec_rs2 = 5'd7; dec_rs2_val = 32'h77; dec_rd = 5'd8;
    eval(); adv();
    dec_valid = 0; ex_fwd_busy = 1; ex_fwd_rd = 5'd7;
    eval(); chk("t5_stall", 64'(alu_valid), FWD ? 64'd0 : 64'd1); adv();
    ex_fwd_busy = 0; ex_fwd_we = 1; ex_fwd_data = 32'h55;
    eval();
    chk("t5_issue", 64'(alu_valid), FWD ? 64'd1 : 64'd0);
    if (alu_valid) chk("t5_inb", 64'(alu_inb), 64'h55);
    adv();
    idle(); eval(); adv();

    // Flush beats a same-cycle enqueue.
    alu_ready = 0; add_instr(32'h5, 32'h6); eval(); adv();
    flush = 1; add_instr(32'h7, 32'h8); eval(); adv();
    flush = 0; dec_valid = 0;
    eval();
    chk("t6_valid", 64'(alu_valid), 64'd0);
    chk("t6_ready", 64'(dec_ready), 64'd1);
    adv();

    // Reset with two entries held.
    add_instr(32'hA, 32'hB); eval(); adv();
    add_instr(32'hC, 32'hD); eval(); adv();
    rst = 1;
    #1;
    chk("t1_valid", 64'(alu_valid), 64'd0);
    chk("t1_ready", 64'(dec_ready), 64'd1);
    eval(); adv();
    rst = 0; dec_valid = 0; alu_ready = 1;
    for (int i = 0; i < 3; i++) begin
      eval(); chk("t1_stale", 64'(alu_valid), 64'd0); adv();
    end

    for (int i = 0; i < 2000; i++) begin
      rand_in();
      eval();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
